// File: rtl/mem_arbiter.sv
// Two-client block-memory arbiter: serialises I-cache fetches and D-cache
// reads/write-backs onto one busywait-driven memory port, alternating on ties.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IC_READ,
  input  logic [ADDR_W-1:0]  IC_ADDR,
  output logic [BLOCK_W-1:0] IC_READDATA,
  output logic               IC_BUSYWAIT,
  input  logic               DC_READ,
  input  logic               DC_WRITE,
  input  logic [ADDR_W-1:0]  DC_ADDR,
  input  logic [BLOCK_W-1:0] DC_WRITEDATA,
  output logic [BLOCK_W-1:0] DC_READDATA,
  output logic               DC_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic [1:0]         GRANT
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_I, WAIT_I, RESP_I, ISSUE_D, WAIT_D, RESP_D
  } state_t;

  state_t state;
  logic   last_d;   // 1: D-cache was the last owner served
  logic   dc_req;

  assign dc_req      = DC_READ | DC_WRITE;
  assign IC_BUSYWAIT = IC_READ & (state != RESP_I);
  assign DC_BUSYWAIT = dc_req  & (state != RESP_D);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WRITEDATA <= '0;
      IC_READDATA   <= '0;
      DC_READDATA   <= '0;
      GRANT         <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // D wins unless the I-cache is also waiting and D went last
          if (dc_req && (!IC_READ || !last_d)) begin
            MEM_ADDR      <= DC_ADDR;
            MEM_WRITEDATA <= DC_WRITEDATA;
            MEM_WRITE     <= DC_WRITE;
            MEM_READ      <= ~DC_WRITE;
            GRANT         <= 2'b10;
            state         <= ISSUE_D;
          end else if (IC_READ) begin
            MEM_ADDR  <= IC_ADDR;
            MEM_READ  <= 1'b1;
            MEM_WRITE <= 1'b0;
            GRANT     <= 2'b01;
            state     <= ISSUE_I;
          end
        end
        // memory raises busywait one cycle late, so the issue cycle never completes
        ISSUE_I: state <= WAIT_I;
        ISSUE_D: state <= WAIT_D;
        WAIT_I: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ    <= 1'b0;
            IC_READDATA <= MEM_READDATA;
            last_d      <= 1'b0;
            GRANT       <= 2'b00;
            state       <= RESP_I;
          end
        end
        WAIT_D: begin
          if (!MEM_BUSYWAIT) begin
            if (MEM_READ) DC_READDATA <= MEM_READDATA;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            last_d    <= 1'b1;
            GRANT     <= 2'b00;
            state     <= RESP_D;
          end
        end
        RESP_I:  state <= IDLE;
        RESP_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: busywait memory model, directed
// scenarios and randomized two-cache traffic against a reference model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  logic          CLK, RESET;
  logic          IC_READ, DC_READ, DC_WRITE;
  logic [AW-1:0] IC_ADDR, DC_ADDR, MEM_ADDR;
  logic [BW-1:0] IC_READDATA, DC_WRITEDATA, DC_READDATA, MEM_WRITEDATA, MEM_READDATA;
  logic          IC_BUSYWAIT, DC_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [1:0]    GRANT;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .CLK(CLK), .RESET(RESET),
    .IC_READ(IC_READ), .IC_ADDR(IC_ADDR), .IC_READDATA(IC_READDATA), .IC_BUSYWAIT(IC_BUSYWAIT),
    .DC_READ(DC_READ), .DC_WRITE(DC_WRITE), .DC_ADDR(DC_ADDR), .DC_WRITEDATA(DC_WRITEDATA),
    .DC_READDATA(DC_READDATA), .DC_BUSYWAIT(DC_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .GRANT(GRANT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // default contents of any block never written
  function automatic logic [BW-1:0] pat(input logic [7:0] a);
    return {24'hC0DE00, a, 24'h5A5A00, a ^ 8'hFF, 8'h00, a, 16'h1234, 24'h0F0F0F, a};
  endfunction

  // memory model: strobe seen for cnt edges; busywait high while cnt < lat
  int            lat = 1;
  int            cnt = 0;
  logic [BW-1:0] mem [256];
  bit            written [256];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [BW-1:0] pre_data = '0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt < lat);
  assign MEM_READDATA = written[MEM_ADDR[7:0]] ? mem[MEM_ADDR[7:0]] : pat(MEM_ADDR[7:0]);

  always @(posedge CLK) begin
    cnt <= (MEM_READ | MEM_WRITE) ? cnt + 1 : 0;
    if (pre_we) begin
      mem[pre_addr]     <= pre_data;
      written[pre_addr] <= 1'b1;
    end else if (MEM_WRITE && !MEM_BUSYWAIT && cnt >= 1) begin
      mem[MEM_ADDR[7:0]]     <= MEM_WRITEDATA;
      written[MEM_ADDR[7:0]] <= 1'b1;
    end
  end

  logic [BW-1:0] exp_dc_rd;

  task automatic do_reset();
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    exp_dc_rd = '0;
  endtask

  task automatic test_reset();
    logic [BW-1:0] wd;
    bit done;
    IC_READ = 0; DC_READ = 0; DC_WRITE = 0; IC_ADDR = '0; DC_ADDR = '0; DC_WRITEDATA = '0;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if ({MEM_READ, MEM_WRITE, GRANT} !== 4'b0000)
      $display("FAIL reset_strobes got %b exp 0000", {MEM_READ, MEM_WRITE, GRANT});
    if ({MEM_READ, MEM_WRITE, GRANT} !== 4'b0000) errors++;
    checks++; if (IC_READDATA !== '0 || DC_READDATA !== '0 || MEM_ADDR !== '0 || MEM_WRITEDATA !== '0) begin
      errors++; $display("FAIL reset_data got ic=%h dc=%h exp 0", IC_READDATA, DC_READDATA);
    end
    checks++; if ({IC_BUSYWAIT, DC_BUSYWAIT} !== 2'b00) begin
      errors++; $display("FAIL reset_busywait got %b exp 00", {IC_BUSYWAIT, DC_BUSYWAIT});
    end
    RESET = 1'b1; exp_dc_rd = '0; lat = 10;
    @(posedge CLK); #1;
    wd = {4{32'h5555AAAA}};
    DC_WRITE = 1; DC_ADDR = 28'h5; DC_WRITEDATA = wd;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if ({MEM_WRITE, GRANT} !== 3'b110) begin
      errors++; $display("FAIL reset_prewait got %b exp 110", {MEM_WRITE, GRANT});
    end
    #2; RESET = 1'b0; #1;
    checks++; if ({MEM_READ, MEM_WRITE, GRANT} !== 4'b0000) begin
      errors++; $display("FAIL reset_async got %b exp 0000", {MEM_READ, MEM_WRITE, GRANT});
    end
    checks++; if (DC_BUSYWAIT !== 1'b1) begin
      errors++; $display("FAIL reset_dc_bw got %b exp 1", DC_BUSYWAIT);
    end
    @(posedge CLK); #1;
    lat = 2; RESET = 1'b1;
    @(posedge CLK); #1;
    checks++; if ({MEM_WRITE, MEM_READ, GRANT} !== 4'b1010 || MEM_ADDR !== 28'h5) begin
      errors++; $display("FAIL reset_reissue got %b addr %h exp 1010 addr 5", {MEM_WRITE, MEM_READ, GRANT}, MEM_ADDR);
    end
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge CLK); #1;
      if (!DC_BUSYWAIT) begin done = 1; DC_WRITE = 0; end
    end
    checks++; if (!done || DC_READDATA !== exp_dc_rd) begin
      errors++; $display("FAIL reset_resume got done=%0d dc=%h exp 1 %h", done, DC_READDATA, exp_dc_rd);
    end
  endtask

  task automatic test_ifetch();
    logic [BW-1:0] blk;
    int rd, bwlow, resp_at;
    blk = 128'hDEADBEEF_00112233_44556677_8899AABB;
    @(posedge CLK); #1;
    lat = 5; pre_addr = 8'h10; pre_data = blk; pre_we = 1'b1;
    @(posedge CLK); #1;
    pre_we = 1'b0;
    IC_READ = 1; IC_ADDR = 28'h0000010;
    rd = 0; bwlow = 0; resp_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (MEM_READ) begin
        rd++;
        checks++; if (MEM_ADDR !== 28'h10 || GRANT !== 2'b01 || MEM_WRITE !== 1'b0) begin
          errors++; $display("FAIL ifetch_port got addr=%h g=%b w=%b exp 10 01 0", MEM_ADDR, GRANT, MEM_WRITE);
        end
      end
      if (IC_READ) begin
        if (!IC_BUSYWAIT) begin bwlow++; if (resp_at == 0) resp_at = c; end
        else if (resp_at != 0) IC_READ = 0;
      end
    end
    checks++; if (rd != 6) begin errors++; $display("FAIL ifetch_read_cycles got %0d exp 6", rd); end
    checks++; if (bwlow != 1) begin errors++; $display("FAIL ifetch_bw_low got %0d exp 1", bwlow); end
    checks++; if (resp_at != 7) begin errors++; $display("FAIL ifetch_turnaround got %0d exp 7", resp_at); end
    checks++; if (IC_READDATA !== blk) begin
      errors++; $display("FAIL ifetch_data got %h exp %h", IC_READDATA, blk);
    end
  endtask

  task automatic test_writeback();
    logic [BW-1:0] wd;
    int wr;
    bit done;
    wd = {4{32'h11111111}};
    @(posedge CLK); #1;
    lat = 3; DC_WRITE = 1; DC_ADDR = 28'h00000A3; DC_WRITEDATA = wd;
    wr = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge CLK); #1;
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL wb_no_read got %b exp 0", MEM_READ); end
      if (MEM_WRITE) begin
        wr++;
        checks++; if (MEM_ADDR !== 28'hA3 || MEM_WRITEDATA !== wd || GRANT !== 2'b10) begin
          errors++; $display("FAIL wb_port got a=%h d=%h g=%b exp a3 %h 10", MEM_ADDR, MEM_WRITEDATA, GRANT, wd);
        end
      end
      if (!DC_BUSYWAIT) begin done = 1; DC_WRITE = 0; end
    end
    checks++; if (!done || wr != 4) begin errors++; $display("FAIL wb_cycles got done=%0d wr=%0d exp 1 4", done, wr); end
    checks++; if (DC_READDATA !== exp_dc_rd) begin
      errors++; $display("FAIL wb_readdata got %h exp %h", DC_READDATA, exp_dc_rd);
    end
    checks++; if (!written[8'hA3] || mem[8'hA3] !== wd) begin
      errors++; $display("FAIL wb_commit got %h exp %h", mem[8'hA3], wd);
    end
  endtask

  task automatic test_tie();
    logic [1:0] seq [4];
    logic [1:0] prev_g;
    int n, comp;
    do_reset();
    lat = 2;
    IC_READ = 1; IC_ADDR = 28'h20; DC_READ = 1; DC_ADDR = 28'h21;
    n = 0; comp = 0; prev_g = 2'b00;
    for (int c = 0; c < 200 && comp < 4; c++) begin
      @(posedge CLK); #1;
      if (GRANT != 2'b00 && prev_g == 2'b00 && n < 4) begin seq[n] = GRANT; n++; end
      prev_g = GRANT;
      if (IC_READ && !IC_BUSYWAIT) begin
        comp++;
        checks++; if (IC_READDATA !== pat(IC_ADDR[7:0])) begin
          errors++; $display("FAIL tie_ic_data got %h exp %h", IC_READDATA, pat(IC_ADDR[7:0]));
        end
        IC_ADDR = IC_ADDR + 2;
      end
      if (DC_READ && !DC_BUSYWAIT) begin
        comp++;
        checks++; if (DC_READDATA !== pat(DC_ADDR[7:0])) begin
          errors++; $display("FAIL tie_dc_data got %h exp %h", DC_READDATA, pat(DC_ADDR[7:0]));
        end
        exp_dc_rd = pat(DC_ADDR[7:0]);
        DC_ADDR = DC_ADDR + 2;
      end
    end
    IC_READ = 0; DC_READ = 0;
    checks++; if (n != 4) begin errors++; $display("FAIL tie_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i < n && seq[i] !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_order[%0d] got %b exp %b", i, seq[i], (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_rw_overlap();
    logic [BW-1:0] wd;
    bit done, seen;
    wd = {$urandom, $urandom, $urandom, $urandom};
    @(posedge CLK); #1;
    lat = 1; DC_READ = 1; DC_WRITE = 1; DC_ADDR = 28'h30; DC_WRITEDATA = wd;
    done = 0; seen = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge CLK); #1;
      if ((MEM_READ || MEM_WRITE) && !seen) begin
        seen = 1;
        checks++; if ({MEM_WRITE, MEM_READ} !== 2'b10) begin
          errors++; $display("FAIL rw_op got w/r=%b exp 10", {MEM_WRITE, MEM_READ});
        end
      end
      if (!DC_BUSYWAIT) begin done = 1; DC_READ = 0; DC_WRITE = 0; end
    end
    checks++; if (!done || DC_READDATA !== exp_dc_rd) begin
      errors++; $display("FAIL rw_readdata got %h exp %h", DC_READDATA, exp_dc_rd);
    end
    checks++; if (mem[8'h30] !== wd) begin errors++; $display("FAIL rw_commit got %h exp %h", mem[8'h30], wd); end
  endtask

  task automatic test_immediate();
    @(posedge CLK); #1;
    lat = 0; IC_READ = 1; IC_ADDR = 28'h31;
    @(posedge CLK); #1;
    checks++; if ({MEM_READ, IC_BUSYWAIT} !== 2'b11) begin
      errors++; $display("FAIL imm_issue got %b exp 11", {MEM_READ, IC_BUSYWAIT});
    end
    @(posedge CLK); #1;
    checks++; if (IC_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL imm_wait got %b exp 1", IC_BUSYWAIT); end
    @(posedge CLK); #1;
    checks++; if (IC_BUSYWAIT !== 1'b0 || IC_READDATA !== pat(8'h31)) begin
      errors++; $display("FAIL imm_ic_resp got bw=%b d=%h exp 0 %h", IC_BUSYWAIT, IC_READDATA, pat(8'h31));
    end
    IC_READ = 0;
    @(posedge CLK); #1;
    DC_READ = 1; DC_ADDR = 28'h32;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (DC_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL imm_dc_wait got %b exp 1", DC_BUSYWAIT); end
    @(posedge CLK); #1;
    checks++; if (DC_BUSYWAIT !== 1'b0 || DC_READDATA !== pat(8'h32)) begin
      errors++; $display("FAIL imm_dc_resp got bw=%b d=%h exp 0 %h", DC_BUSYWAIT, DC_READDATA, pat(8'h32));
    end
    exp_dc_rd = pat(8'h32);
    DC_READ = 0;
  endtask

  task automatic test_random();
    logic [BW-1:0] ref_mem [16];
    logic [3:0]    ic_a, dc_a;
    logic [1:0]    prev_g, exp_g;
    bit            last_d, pic, pdc, abort;
    int            ic_wait, dc_wait, ncomp;
    logic [BW-1:0] mv;
    for (int i = 0; i < 16; i++) ref_mem[i] = pat(8'h40 + 8'(i));
    do_reset();
    last_d = 0; prev_g = 2'b00; ic_wait = 0; dc_wait = 0; ncomp = 0; abort = 0;
    ic_a = '0; dc_a = '0;
    for (int c = 0; c < 900 && !abort; c++) begin
      if (c >= 600 && !IC_READ && !DC_READ && !DC_WRITE) break;
      if (!MEM_READ && !MEM_WRITE && c % 40 == 0) lat = int'($urandom_range(0, 4));
      pic = IC_READ; pdc = DC_READ | DC_WRITE;
      @(posedge CLK); #1;
      if (GRANT != 2'b00 && prev_g == 2'b00) begin
        exp_g = (pic && pdc) ? (last_d ? 2'b01 : 2'b10) : pdc ? 2'b10 : pic ? 2'b01 : 2'b00;
        checks++; if (GRANT !== exp_g) begin
          errors++; $display("FAIL rand_grant got %b exp %b (ic=%0d dc=%0d)", GRANT, exp_g, pic, pdc);
        end
      end
      prev_g = GRANT;
      if (IC_READ) begin
        if (!IC_BUSYWAIT) begin
          ncomp++; last_d = 0; ic_wait = 0;
          checks++; if (IC_READDATA !== ref_mem[ic_a]) begin
            errors++; $display("FAIL rand_ic_data got %h exp %h", IC_READDATA, ref_mem[ic_a]);
          end
          ic_a = 4'($urandom); IC_ADDR = 28'h40 + 28'(ic_a);
          IC_READ = (c < 600) && ($urandom % 2 == 0);
        end else if (++ic_wait > 80) begin
          errors++; abort = 1; $display("FAIL rand_ic_timeout got %0d exp <=80", ic_wait);
        end
      end else if (c < 600 && $urandom % 3 == 0) begin
        ic_a = 4'($urandom); IC_ADDR = 28'h40 + 28'(ic_a); IC_READ = 1;
      end
      if (DC_READ || DC_WRITE) begin
        if (!DC_BUSYWAIT) begin
          ncomp++; last_d = 1; dc_wait = 0;
          if (DC_WRITE) begin
            ref_mem[dc_a] = DC_WRITEDATA;
            checks++; if (DC_READDATA !== exp_dc_rd) begin
              errors++; $display("FAIL rand_dc_keep got %h exp %h", DC_READDATA, exp_dc_rd);
            end
          end else begin
            checks++; if (DC_READDATA !== ref_mem[dc_a]) begin
              errors++; $display("FAIL rand_dc_data got %h exp %h", DC_READDATA, ref_mem[dc_a]);
            end
            exp_dc_rd = ref_mem[dc_a];
          end
          DC_READ = 0; DC_WRITE = 0;
        end else if (++dc_wait > 80) begin
          errors++; abort = 1; $display("FAIL rand_dc_timeout got %0d exp <=80", dc_wait);
        end
      end
      if (!DC_READ && !DC_WRITE && c < 600 && $urandom % 2 == 0) begin
        dc_a = 4'($urandom); DC_ADDR = 28'h40 + 28'(dc_a);
        DC_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom % 4)
          0, 1:    begin DC_READ = 1; DC_WRITE = 0; end
          2:       begin DC_READ = 0; DC_WRITE = 1; end
          default: begin DC_READ = 1; DC_WRITE = 1; end
        endcase
      end
    end
    IC_READ = 0; DC_READ = 0; DC_WRITE = 0;
    checks++; if (ncomp < 40) begin errors++; $display("FAIL rand_progress got %0d exp >=40", ncomp); end
    for (int i = 0; i < 16; i++) begin
      mv = written[8'h40 + 8'(i)] ? mem[8'h40 + 8'(i)] : pat(8'h40 + 8'(i));
      checks++; if (mv !== ref_mem[i]) begin
        errors++; $display("FAIL rand_mem[%0d] got %h exp %h", i, mv, ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_writeback();
    test_tie();
    test_rw_overlap();
    test_immediate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
